// File: rtl/roi_ctrl.sv
// roi_ctrl: sequencer and configuration controller for the ROI crop datapath.
// It validates ROI requests into a one-entry shadow and commits the shadow to
// the cropper only between frames. It gates the input stream on whole frames,
// in continuous or single-shot mode, and counts the gated frames.
module roi_ctrl #(
   parameter int WIDTH  = 800,
   parameter int HEIGHT = 600,
   parameter int BIT_C  = 32,
   parameter int FCNT_W = 16
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [BIT_C-1:0]  cfg_xy0_i,
   input  logic [BIT_C-1:0]  cfg_xy1_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              single_i,
   input  logic              s_tvalid_i,
   input  logic              s_tlast_i,
   output logic [BIT_C-1:0]  xy_0_o,
   output logic [BIT_C-1:0]  xy_1_o,
   output logic              gate_o,
   output logic              busy_o,
   output logic              cfg_err_o,
   output logic [FCNT_W-1:0] frame_cnt_o,
   output logic              frame_done_o
);

   localparam logic [10:0] X_MAX = 11'(WIDTH);
   localparam logic [9:0]  Y_MAX = 10'(HEIGHT);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_STOPPING = 2'd3
   } state_t;

   // Repack a request word so only the x/y fields reach the cropper.
   function automatic logic [BIT_C-1:0] pack_xy(input logic [BIT_C-1:0] w);
      pack_xy = {5'b0, w[26:16], 6'b0, w[9:0]};
   endfunction

   state_t             state_q, state_d;
   logic               single_q, single_d;
   logic               sof_pend_q, sof_pend_d;
   logic               act_vld_q, act_vld_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic               cfg_err_q, cfg_err_d;
   logic [BIT_C-1:0]   shd_0_q, shd_0_d;
   logic [BIT_C-1:0]   shd_1_q, shd_1_d;
   logic [BIT_C-1:0]   xy_0_q, xy_0_d;
   logic [BIT_C-1:0]   xy_1_q, xy_1_d;
   logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic               frame_done_q, frame_done_d;

   logic               eof_s;
   logic               frame_evt_s;
   logic               accept_s;
   logic               cfg_ok_s;
   logic               commit_s;

   assign eof_s = s_tvalid_i & s_tlast_i;

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q      <= ST_IDLE;
         single_q     <= 1'b0;
         sof_pend_q   <= 1'b1;
         act_vld_q    <= 1'b0;
         cfg_ready_q  <= 1'b1;
         cfg_err_q    <= 1'b0;
         shd_0_q      <= '0;
         shd_1_q      <= '0;
         xy_0_q       <= '0;
         xy_1_q       <= '0;
         frame_cnt_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         single_q     <= single_d;
         sof_pend_q   <= sof_pend_d;
         act_vld_q    <= act_vld_d;
         cfg_ready_q  <= cfg_ready_d;
         cfg_err_q    <= cfg_err_d;
         shd_0_q      <= shd_0_d;
         shd_1_q      <= shd_1_d;
         xy_0_q       <= xy_0_d;
         xy_1_q       <= xy_1_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state logic: frames are gated whole; stop has priority over start.
   always_comb begin
      state_d     = state_q;
      single_d    = single_q;
      frame_evt_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && act_vld_q && !stop_i) begin
               state_d  = ST_ARMED;
               single_d = single_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (stop_i) begin
               state_d = ST_IDLE;
            end else if ((sof_pend_q && !s_tvalid_i) || eof_s) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_ARMED;
            end
         end
         ST_ACTIVE: begin
            if (eof_s) begin
               frame_evt_s = 1'b1;
               if (single_q || stop_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ACTIVE;
               end
            end else if (stop_i) begin
               if (sof_pend_q && !s_tvalid_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_STOPPING;
               end
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_STOPPING: begin
            if (eof_s) begin
               frame_evt_s = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_STOPPING;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request validation, shadow commit at frame boundaries, frame counting.
   always_comb begin
      accept_s = cfg_valid_i & cfg_ready_q;
      cfg_ok_s = (cfg_xy0_i[26:16] < cfg_xy1_i[26:16]) &&
                 (cfg_xy0_i[9:0] <= cfg_xy1_i[9:0]) &&
                 (cfg_xy1_i[26:16] <= X_MAX) &&
                 (cfg_xy1_i[9:0] < Y_MAX);
      commit_s = !cfg_ready_q &&
                 (eof_s || (((state_q == ST_IDLE) || (state_q == ST_ARMED)) && sof_pend_q));

      sof_pend_d  = sof_pend_q;
      act_vld_d   = act_vld_q;
      cfg_ready_d = cfg_ready_q;
      cfg_err_d   = cfg_err_q;
      shd_0_d     = shd_0_q;
      shd_1_d     = shd_1_q;
      xy_0_d      = xy_0_q;
      xy_1_d      = xy_1_q;

      if (eof_s) begin
         sof_pend_d = 1'b1;
      end else if (s_tvalid_i) begin
         sof_pend_d = 1'b0;
      end else begin
         sof_pend_d = sof_pend_q;
      end

      // accept and commit are exclusive: accept needs ready, commit needs !ready
      if (accept_s) begin
         if (cfg_ok_s) begin
            shd_0_d     = pack_xy(cfg_xy0_i);
            shd_1_d     = pack_xy(cfg_xy1_i);
            cfg_ready_d = 1'b0;
            cfg_err_d   = 1'b0;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else if (commit_s) begin
         xy_0_d      = shd_0_q;
         xy_1_d      = shd_1_q;
         act_vld_d   = 1'b1;
         cfg_ready_d = 1'b1;
      end else begin
         cfg_ready_d = cfg_ready_q;
      end

      if (frame_evt_s) begin
         frame_cnt_d = frame_cnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
      frame_done_d = frame_evt_s;
   end

   // Output decode: gate and busy follow the state register directly.
   always_comb begin
      gate_o       = (state_q == ST_ACTIVE) || (state_q == ST_STOPPING);
      busy_o       = (state_q != ST_IDLE);
      cfg_ready_o  = cfg_ready_q;
      cfg_err_o    = cfg_err_q;
      xy_0_o       = xy_0_q;
      xy_1_o       = xy_1_q;
      frame_cnt_o  = frame_cnt_q;
      frame_done_o = frame_done_q;
   end

endmodule
